// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_STOP2_EN to end every frame with a second stop bit (STOP2 state).
module uart_tx (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        fill,
    input  logic [7:0]  tx_data,
    input  logic [1:0]  parity,
    input  logic [31:0] div,
    output logic        tx,
    output logic        empty
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
`ifdef UART_TX_STOP2_EN
        ,
        STOP2  = 3'd5
`endif
    } state_t;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [31:0] period_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        par_en_q;
    logic        par_bit_q;
    logic        tx_q;
    logic        empty_q;
    logic        bit_end_s;

    // Even mode sends the XOR of the data bits, odd mode its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        return (^data) ^ (mode == 2'b10);
    endfunction

    assign tx    = tx_q;
    assign empty = empty_q;

    // period_q is never below 1 while framing, so period_q - 1 cannot wrap.
    assign bit_end_s = (cnt_q == (period_q - 32'd1));

    // Frame sequencer: state, bit timing, shift register and registered line outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            period_q  <= 32'd0;
            idx_q     <= 3'd0;
            shift_q   <= 8'd0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            empty_q   <= 1'b0;
        end else if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
            empty_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 32'd0;
                    idx_q <= 3'd0;
                    if (empty_q && fill) begin
                        state_q   <= START;
                        shift_q   <= tx_data;
                        period_q  <= (div == 32'd0) ? 32'd1 : div;
                        par_en_q  <= parity[0] ^ parity[1];
                        par_bit_q <= parity_bit(tx_data, parity);
                        tx_q      <= 1'b0;
                        empty_q   <= 1'b0;
                    end else begin
                        tx_q    <= 1'b1;
                        empty_q <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        state_q <= DATA;
                        cnt_q   <= 32'd0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                DATA: begin
                    if (!bit_end_s) begin
                        cnt_q <= cnt_q + 32'd1;
                    end else if (idx_q == 3'd7) begin
                        cnt_q <= 32'd0;
                        idx_q <= 3'd0;
                        if (par_en_q) begin
                            state_q <= PARITY;
                            tx_q    <= par_bit_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= 32'd0;
                        idx_q   <= idx_q + 3'd1;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        state_q <= STOP;
                        cnt_q   <= 32'd0;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        cnt_q <= 32'd0;
`ifdef UART_TX_STOP2_EN
                        state_q <= STOP2;
`else
                        state_q <= IDLE;
                        empty_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
`ifdef UART_TX_STOP2_EN
                STOP2: begin
                    if (bit_end_s) begin
                        state_q <= IDLE;
                        cnt_q   <= 32'd0;
                        empty_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 32'd0;
                    idx_q   <= 3'd0;
                    tx_q    <= 1'b1;
                    empty_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; frame expectations are built from the
// frame format (start, data LSB first, parity, stop bits), not from the design.
module tb_uart_tx;

`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        fill;
    logic [7:0]  tx_data;
    logic [1:0]  parity;
    logic [31:0] div;
    logic        tx;
    logic        empty;

    int n_checks = 0;
    int n_fails  = 0;

    uart_tx dut (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .fill    (fill),
        .tx_data (tx_data),
        .parity  (parity),
        .div     (div),
        .tx      (tx),
        .empty   (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte with fill high; the next edge must accept it.
    task automatic start_frame(input logic [7:0] d, input logic [1:0] par, input logic [31:0] dv);
        tx_data = d;
        parity  = par;
        div     = dv;
        fill    = 1'b1;
        tick();
        check("accept tx", {31'd0, tx}, 32'd0);
        check("accept empty", {31'd0, empty}, 32'd0);
        fill = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; checks every cycle of the frame.
    task automatic run_frame(input string tag, input logic [7:0] d, input int p, input logic [1:0] par);
        logic [12:0] bits;
        int n;
        int bad_tx;
        int bad_e;
        bits   = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        n = 9;
        if (par == 2'b01 || par == 2'b10) begin
            bits[9] = (^d) ^ (par == 2'b10);
            n = 10;
        end
        n = n + NSTOP;
        bad_tx = 0;
        bad_e  = 0;
        for (int k = 0; k < n * p; k++) begin
            if (tx !== bits[k / p]) bad_tx++;
            if (empty !== 1'b0) bad_e++;
            tick();
        end
        check({tag, " tx bit errors"}, bad_tx, 32'd0);
        check({tag, " early empty"}, bad_e, 32'd0);
        check({tag, " end empty"}, {31'd0, empty}, 32'd1);
        check({tag, " end tx"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        logic [7:0] bcur;
        logic [7:0] bnext;
        int gap_bad;

        rstn    = 1'b0;
        enable  = 1'b1;
        fill    = 1'b0;
        tx_data = 8'h00;
        parity  = 2'b00;
        div     = 32'd48;
        repeat (3) tick();
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset empty", {31'd0, empty}, 32'd0);
        rstn = 1'b1;
        tick();
        check("post-reset empty", {31'd0, empty}, 32'd1);

        // Basic frame; div/parity changed after start must not affect it.
        start_frame(8'h41, 2'b00, 32'd48);
        div    = 32'd5;
        parity = 2'b01;
        run_frame("basic", 8'h41, 48, 2'b00);

        start_frame(8'h41, 2'b01, 32'd48);
        run_frame("even", 8'h41, 48, 2'b01);
        start_frame(8'h41, 2'b10, 32'd48);
        run_frame("odd", 8'h41, 48, 2'b10);
        start_frame(8'hA5, 2'b11, 32'd3);
        run_frame("par11", 8'hA5, 3, 2'b11);

        start_frame(8'h96, 2'b00, 32'd0);
        run_frame("div0", 8'h96, 1, 2'b00);
        start_frame(8'h5A, 2'b01, 32'd1);
        run_frame("div1", 8'h5A, 1, 2'b01);

        // Abort during the third bit (data bit 1 of 8'h41 is 0).
        start_frame(8'h41, 2'b00, 32'd8);
        repeat (19) tick();
        check("pre-abort tx", {31'd0, tx}, 32'd0);
        enable = 1'b0;
        tick();
        check("abort tx", {31'd0, tx}, 32'd1);
        check("abort empty", {31'd0, empty}, 32'd0);
        fill = 1'b1;
        tick();
        check("disabled empty", {31'd0, empty}, 32'd0);
        check("disabled tx", {31'd0, tx}, 32'd1);
        fill   = 1'b0;
        enable = 1'b1;
        tick();
        check("re-enable empty", {31'd0, empty}, 32'd1);
        start_frame(8'hC3, 2'b10, 32'd8);
        run_frame("after abort", 8'hC3, 8, 2'b10);

        // Back-to-back frames with fill held high.
        gap_bad = 0;
        bcur    = 8'($urandom_range(126, 33));
        start_frame(bcur, 2'b00, 32'd4);
        fill = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bnext   = 8'($urandom_range(126, 33));
            tx_data = bnext;
            run_frame("handshake", bcur, 4, 2'b00);
            if (i == 99) fill = 1'b0;
            tick();
            if (i < 99 && (tx !== 1'b0 || empty !== 1'b0)) gap_bad++;
            bcur = bnext;
        end
        check("handshake gaps", gap_bad, 32'd0);
        check("handshake final empty", {31'd0, empty}, 32'd1);

        // Asynchronous reset mid-frame.
        start_frame(8'h00, 2'b00, 32'd4);
        repeat (5) tick();
        check("pre-reset tx", {31'd0, tx}, 32'd0);
        rstn = 1'b0;
        #1;
        check("async reset tx", {31'd0, tx}, 32'd1);
        check("async reset empty", {31'd0, empty}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("resume empty", {31'd0, empty}, 32'd1);
        start_frame(8'h3C, 2'b01, 32'd2);
        run_frame("after reset", 8'h3C, 2, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port enable, input, 1 bit: 1 = transmitter operating; 0 = held idle.
REQ-004 SHALL have port fill, input, 1 bit: request to load tx_data and start a frame.
REQ-005 SHALL have port tx_data, input, 8 bits: byte to send.
REQ-006 SHALL have port parity, input, 2 bits: 00 none, 01 even, 10 odd, 11 none.
REQ-007 SHALL have port div, input, 32 bits: clk cycles per bit period.
REQ-008 SHALL have port tx, output, 1 bit: serial line; idle high.
REQ-009 SHALL have port empty, output, 1 bit: 1 = idle and ready to accept fill.

Function
REQ-010 SHALL use states IDLE, START, DATA, PARITY, STOP (STOP2 when enabled per REQ-024), encoded in registers.
REQ-011 SHALL make the bit period max(div,1) clk cycles; div=0 and div=1 both give one cycle per bit.
REQ-012 SHALL sample div and parity at frame start and hold them for the whole frame.
REQ-013 SHALL drive empty=1 only when in IDLE with enable=1; empty is registered.
REQ-014 SHALL accept a frame when fill=1 and empty=1 at a rising edge: latch tx_data, enter START, and on that same edge set tx=0 and empty=0.
REQ-015 SHALL ignore fill while empty=0, with no queuing.
REQ-016 SHALL transmit a frame as: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1), each lasting one bit period.
REQ-017 SHALL compute the parity bit as XOR of the 8 data bits for even mode and its inverse for odd mode, and SHALL omit the PARITY state for modes 00 and 11.
REQ-018 SHALL return to IDLE and set empty=1 on the edge ending the final stop-bit period.
REQ-019 SHALL support back-to-back frames: if fill is still 1 when empty rises, the next start bit begins on the following edge.
REQ-020 SHALL drive tx from a register, glitch-free, 1 outside a frame.
REQ-021 SHALL, when enable goes 0 (including mid-frame), abort the frame within one cycle: go to IDLE, tx=1, empty=0; on re-enable, empty=1 on the next edge.
REQ-022 SHALL use a 32-bit bit-period counter and a 3-bit data-bit index, with no wrap artefacts at div=32'hFFFFFFFF.

Reset
REQ-023 SHALL, while rstn=0 (asynchronous), force state=IDLE, tx=1, empty=0, and clear all counters and the shift register; operation resumes on the first clk edge after release.

Configuration
REQ-024 SHALL gate a second stop bit with macro UART_TX_STOP2_EN: when defined, each frame ends with two stop-bit periods (STOP then STOP2) before IDLE; when undefined, one stop bit only and the STOP2 state does not exist.

Verification
REQ-025 SHALL verify reset: rstn=0 -> tx=1, empty=0; rstn=1, enable=1 -> empty=1 after one edge.
REQ-026 SHALL verify a basic frame: div=48, parity=00, tx_data=8'h41, fill pulse -> tx line reads 0,1,0,0,0,0,0,1,0,1 with each bit 48 cycles; empty low 480 cycles, then high.
REQ-027 SHALL verify parity: tx_data=8'h41 with parity=01 -> parity bit 0; with parity=10 -> parity bit 1; frame length 11 bit periods.
REQ-028 SHALL verify the handshake: fill held high, data changed after each empty fall, 100 random bytes in 33..126 -> each byte decoded correctly on tx, no gaps beyond one cycle between frames.
REQ-029 SHALL verify abort: enable=0 mid DATA -> tx=1 and empty=0 next cycle; re-enable -> empty=1, next frame correct.
REQ-030 SHALL verify the edge divider: div=0 and div=1 -> one-cycle bits; with UART_TX_STOP2_EN defined, div=48 -> stop high for 96 cycles.
